// File: rtl/ksz_bus_pkg.sv
// rtl/ksz_bus_pkg.sv - shared constants and types for the KSZ8851 bus arbiter
package ksz_bus_pkg;

    // KSZ8851 access-engine state encodings as reported on its 4-bit state port
    localparam logic [3:0] ENG_ADDR0  = 4'd0;
    localparam logic [3:0] ENG_ADDR1  = 4'd1;
    localparam logic [3:0] ENG_ADDR2  = 4'd2;
    localparam logic [3:0] ENG_READ0  = 4'd3;
    localparam logic [3:0] ENG_READ1  = 4'd4;
    localparam logic [3:0] ENG_READ2  = 4'd5;
    localparam logic [3:0] ENG_WRITE0 = 4'd6;
    localparam logic [3:0] ENG_WRITE1 = 4'd7;
    localparam logic [3:0] ENG_WRITE2 = 4'd8;
    localparam logic [3:0] ENG_WAIT   = 4'd9;

    localparam int NREQ_MAX = 4;
    localparam int IDX_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Index of the highest set bit of a one-hot vector (0 when empty)
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NREQ_MAX-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ksz_bus_arbiter_if.sv
// rtl/ksz_bus_arbiter_if.sv - requester and engine command bus of the KSZ8851 arbiter
//
// Requester side: req, lock, dma, req_wr, req_offset, req_length, req_wdata in;
//                 gnt, done, err, rdata out.
// Engine side:    NewCommand, WR, offset, length, writeData, Dummy_Read out;
//                 readData, state in.
// master = arbiter view, slave = sequencers plus engine view.
interface ksz_bus_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ-1:0]      dma;
    logic [NREQ-1:0]      req_wr;
    logic [8*NREQ-1:0]    req_offset;
    logic [NREQ-1:0]      req_length;
    logic [16*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic [15:0]          rdata;

    logic                 NewCommand;
    logic                 WR;
    logic [7:0]           offset;
    logic                 length;
    logic [15:0]          writeData;
    logic                 Dummy_Read;
    logic [15:0]          readData;
    logic [3:0]           state;

    modport master (
        input  req, lock, dma, req_wr, req_offset, req_length, req_wdata,
        input  readData, state,
        output gnt, done, err, rdata,
        output NewCommand, WR, offset, length, writeData, Dummy_Read
    );

    modport slave (
        output req, lock, dma, req_wr, req_offset, req_length, req_wdata,
        output readData, state,
        input  gnt, done, err, rdata,
        input  NewCommand, WR, offset, length, writeData, Dummy_Read
    );
endinterface

// File: rtl/ksz_bus_arbiter_rr_pick.sv
// rtl/ksz_bus_arbiter_rr_pick.sv - combinational round-robin picker
//
// Ports: req (N) requests, last (index of previous winner) in;
//        win (N, one-hot) and valid out. Search starts at last+1 and wraps.
module rr_pick
    import ksz_bus_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     win,
    output logic             valid
);

    always_comb begin
        int idx;
        win = '0;
        idx = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) idx = idx - N;
            if (win == '0 && req[IDX_W'(idx)]) win[IDX_W'(idx)] = 1'b1;
        end
    end

    assign valid = |win;

endmodule

// File: rtl/ksz_bus_arbiter.sv
// rtl/ksz_bus_arbiter.sv - shares the KSZ8851 register/DMA engine among sequencers
//
// Ports: clk40m, reset (async, active-high), bus (ksz_bus_arbiter_if.master).
// Parameters: NREQ (2..4 requesters), TIMEOUT (cycles per transaction, 8-bit).
// Optional macro KSZ_ARB_TIMEOUT_EN adds a per-transaction timeout that
// completes the transaction with err; without it err is tied low.
module ksz_bus_arbiter
    import ksz_bus_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk40m,
    input  logic              reset,
    ksz_bus_arbiter_if.master bus
);

    if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("ksz_bus_arbiter: unsupported NREQ or TIMEOUT");
    end

    arb_state_t        st_q, st_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  g_q, g_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              newcmd_q, newcmd_d;
    logic              wr_q, wr_d;
    logic [7:0]        offset_q, offset_d;
    logic              length_q, length_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              dummy_q, dummy_d;
    logic              load;
    logic [IDX_W-1:0]  load_idx;
    logic              timed_out;

    logic [NREQ-1:0]   pick_win;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick #(.N(NREQ)) u_pick (
        .req   (bus.req),
        .last  (last_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign pick_idx = onehot_idx(NREQ_MAX'(pick_win));

`ifdef KSZ_ARB_TIMEOUT_EN
    logic [7:0]        cnt_q, cnt_d;
    logic [NREQ-1:0]   err_q, err_d;
    // err stays high through DONE, so it also marks the grant as non-renewable
    assign timed_out = |err_q;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        st_d     = st_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        last_d   = last_q;
        g_d      = g_q;
        rdata_d  = rdata_q;
        newcmd_d = newcmd_q;
        wr_d     = wr_q;
        offset_d = offset_q;
        length_d = length_q;
        wdata_d  = wdata_q;
        load     = 1'b0;
        load_idx = g_q;
`ifdef KSZ_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = '0;
`endif

        case (st_q)
            IDLE: begin
                if (pick_valid) begin
                    load     = 1'b1;
                    load_idx = pick_idx;
                    gnt_d    = pick_win;
                    g_d      = pick_idx;
                    newcmd_d = 1'b1;
                    st_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.state != ENG_WAIT) begin
                    newcmd_d = 1'b0;
                    st_d     = BUSY;
                end
            end
            BUSY: begin
                if (bus.state == ENG_WAIT) begin
                    done_d[g_q] = 1'b1;
                    rdata_d     = wr_q ? 16'h0000 : bus.readData;
                    st_d        = DONE;
                end
            end
            DONE: begin
                if (bus.lock[g_q] && bus.req[g_q] && !timed_out) begin
                    load     = 1'b1;
                    load_idx = g_q;
                    newcmd_d = 1'b1;
                    st_d     = ISSUE;
                end else begin
                    last_d = g_q;
                    gnt_d  = '0;
                    st_d   = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase

`ifdef KSZ_ARB_TIMEOUT_EN
        if (st_q == ISSUE || st_q == BUSY) begin
            if (cnt_q == 8'(TIMEOUT)) begin
                newcmd_d    = 1'b0;
                done_d      = '0;
                done_d[g_q] = 1'b1;
                err_d[g_q]  = 1'b1;
                rdata_d     = 16'h0000;
                st_d        = DONE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        if (st_d == ISSUE && st_q != ISSUE) cnt_d = 8'd0;
`endif

        if (load) begin
            wr_d     = bus.req_wr[load_idx];
            offset_d = bus.req_offset[{load_idx, 3'b000} +: 8];
            length_d = bus.req_length[load_idx];
            wdata_d  = bus.req_wr[load_idx] ? bus.req_wdata[{load_idx, 4'b0000} +: 16] : 16'h0000;
        end

        dummy_d = (|gnt_d) & bus.dma[g_d];
    end

    always_ff @(posedge clk40m or posedge reset) begin
        if (reset) begin
            st_q     <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            last_q   <= IDX_W'(NREQ - 1);
            g_q      <= '0;
            rdata_q  <= '0;
            newcmd_q <= 1'b0;
            wr_q     <= 1'b0;
            offset_q <= '0;
            length_q <= 1'b0;
            wdata_q  <= '0;
            dummy_q  <= 1'b0;
`ifdef KSZ_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= '0;
`endif
        end else begin
            st_q     <= st_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            last_q   <= last_d;
            g_q      <= g_d;
            rdata_q  <= rdata_d;
            newcmd_q <= newcmd_d;
            wr_q     <= wr_d;
            offset_q <= offset_d;
            length_q <= length_d;
            wdata_q  <= wdata_d;
            dummy_q  <= dummy_d;
`ifdef KSZ_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.rdata      = rdata_q;
    assign bus.NewCommand = newcmd_q;
    assign bus.WR         = wr_q;
    assign bus.offset     = offset_q;
    assign bus.length     = length_q;
    assign bus.writeData  = wdata_q;
    assign bus.Dummy_Read = dummy_q;
`ifdef KSZ_ARB_TIMEOUT_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = '0;
`endif

endmodule

// File: tb/tb_ksz_bus_arbiter.sv
// tb/tb_ksz_bus_arbiter.sv - directed self-checking bench for ksz_bus_arbiter
module tb_ksz_bus_arbiter;
    import ksz_bus_pkg::*;

    logic clk40m;
    logic reset;
    logic eng_stall;
    logic eng_wr;

    int n_assert;
    int n_fail;

    ksz_bus_arbiter_if #(.NREQ(3)) bus ();

    ksz_bus_arbiter #(.NREQ(3), .TIMEOUT(20)) dut (
        .clk40m (clk40m),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk40m = 1'b0;
    always #12.5 clk40m = ~clk40m;

    // Engine model: accepts NewCommand in Wait, walks Addr0..2 then Read0..2 or Write0..2
    always_ff @(posedge clk40m or posedge reset) begin
        if (reset) begin
            bus.state    <= ENG_WAIT;
            bus.readData <= '0;
            eng_wr       <= 1'b0;
        end else begin
            case (bus.state)
                ENG_WAIT: begin
                    if (bus.NewCommand && !eng_stall) begin
                        bus.state    <= ENG_ADDR0;
                        eng_wr       <= bus.WR;
                        bus.readData <= (bus.offset == 8'h92) ? 16'h2000 : {8'hA5, bus.offset};
                    end
                end
                ENG_ADDR2:             bus.state <= eng_wr ? ENG_WRITE0 : ENG_READ0;
                ENG_READ2, ENG_WRITE2: bus.state <= ENG_WAIT;
                default:               bus.state <= bus.state + 4'd1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk40m);
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.gnt == '0 && n < 40);
        if (bus.gnt == '0) chk({tag, "_gnt_timeout"}, 64'(bus.gnt), 64'h1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done == '0 && n < 60);
        if (bus.done == '0) chk({tag, "_done_timeout"}, 64'(bus.done), 64'h1);
    endtask

    logic [7:0]  exp_off [3];
    logic [15:0] exp_wd  [3];
    logic        bad;
    int          cnt;
    int          r;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        eng_stall = 1'b0;
        bus.req = '0; bus.lock = '0; bus.dma = '0; bus.req_wr = '0;
        bus.req_offset = '0; bus.req_length = '0; bus.req_wdata = '0;
        tick(); tick();

        // Reset state
        chk("reset_outputs", 64'({bus.gnt, bus.done, bus.err, bus.rdata, bus.NewCommand, bus.WR,
            bus.offset, bus.length, bus.writeData, bus.Dummy_Read}), 64'h0);
        reset = 1'b0;
        tick();

        // Single read by requester 1 at 0x92
        bus.req_offset[15:8] = 8'h92;
        bus.req_wdata[31:16] = 16'h1234;
        bus.req_length[1]    = 1'b1;
        bus.req[1]           = 1'b1;
        tick();
        chk("rd_gnt", 64'(bus.gnt), 64'b010);
        chk("rd_newcmd_0", 64'(bus.NewCommand), 64'h1);
        chk("rd_offset", 64'(bus.offset), 64'h92);
        chk("rd_length", 64'(bus.length), 64'h1);
        chk("rd_wdata_zero", 64'(bus.writeData), 64'h0);
        tick();
        // Engine is only seen leaving Wait on the next edge, so the pulse spans two cycles
        chk("rd_newcmd_1", 64'(bus.NewCommand), 64'h1);
        tick();
        chk("rd_newcmd_fall", 64'(bus.NewCommand), 64'h0);
        wait_done("rd");
        chk("rd_done", 64'(bus.done), 64'b010);
        chk("rd_rdata", 64'(bus.rdata), 64'h2000);
        bus.req = '0;
        tick();
        chk("rd_done_one_cycle", 64'(bus.done), 64'h0);
        chk("rd_gnt_clear", 64'(bus.gnt), 64'h0);

        // Simultaneous writes from all three; reset restarts the rotation at 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_off[0] = 8'h90; exp_wd[0] = 16'hEB00;
        exp_off[1] = 8'h91; exp_wd[1] = 16'h1111;
        exp_off[2] = 8'h92; exp_wd[2] = 16'h2222;
        bus.req_wr     = 3'b111;
        bus.req_offset = {exp_off[2], exp_off[1], exp_off[0]};
        bus.req_wdata  = {exp_wd[2], exp_wd[1], exp_wd[0]};
        bus.req        = 3'b111;
        for (int i = 0; i < 4; i++) begin
            r = i % 3;
            wait_gnt("rr");
            chk($sformatf("rr%0d_gnt", i), 64'(bus.gnt), 64'(3'b001 << r));
            chk($sformatf("rr%0d_wdata", i), 64'(bus.writeData), 64'(exp_wd[r]));
            chk($sformatf("rr%0d_offset", i), 64'(bus.offset), 64'(exp_off[r]));
            wait_done("rr");
            chk($sformatf("rr%0d_done", i), 64'(bus.done), 64'(3'b001 << r));
            chk($sformatf("rr%0d_rdata", i), 64'(bus.rdata), 64'h0);
            if (i == 3) bus.req = '0;
        end

        // Locked DMA burst of 5 reads by requester 1 while requester 0 waits
        bus.req_wr     = '0;
        bus.req_offset = {8'h00, 8'h10, 8'h30};
        bus.lock       = 3'b010;
        bus.dma        = 3'b010;
        bus.req        = 3'b011;
        wait_gnt("dma");
        chk("dma_gnt", 64'(bus.gnt), 64'b010);
        bad = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cnt = 0;
            while (bus.done == '0 && cnt < 60) begin
                if (bus.Dummy_Read !== 1'b1 || bus.gnt !== 3'b010) bad = 1'b1;
                tick();
                cnt++;
            end
            chk($sformatf("dma_done%0d", k), 64'(bus.done), 64'b010);
            chk($sformatf("dma_rdata%0d", k), 64'(bus.rdata), 64'hA510);
            if (k == 4) begin
                tick();
                bus.lock = '0;
            end
            if (k == 5) bus.req[1] = 1'b0;
        end
        chk("dma_held", 64'(bad), 64'h0);
        wait_gnt("dma_after");
        chk("dma_next_gnt", 64'(bus.gnt), 64'b001);
        chk("dma_dummy_off", 64'(bus.Dummy_Read), 64'h0);
        wait_done("dma_r0");
        chk("dma_r0_rdata", 64'(bus.rdata), 64'hA530);
        bus.req = '0;
        bus.dma = '0;

        // Requester 2 drops req during BUSY
        bus.req_offset[23:16] = 8'h44;
        bus.req = 3'b100;
        wait_gnt("drop");
        cnt = 0;
        while (bus.NewCommand && cnt < 20) begin
            tick();
            cnt++;
        end
        bus.req = '0;
        wait_done("drop");
        chk("drop_done", 64'(bus.done), 64'b100);
        chk("drop_rdata", 64'(bus.rdata), 64'hA544);
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.gnt !== 3'b000) bad = 1'b1;
        end
        chk("drop_no_regrant", 64'(bad), 64'h0);

        // Reset while the engine is in Read1
        bus.req_offset[15:8] = 8'h20;
        bus.req = 3'b010;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.state != ENG_READ1 && cnt < 40);
        chk("rst_reached_read1", 64'(bus.state), 64'(ENG_READ1));
        reset = 1'b1;
        #1;
        chk("rst_async_clear", 64'({bus.gnt, bus.done, bus.err, bus.rdata, bus.NewCommand, bus.WR,
            bus.offset, bus.length, bus.writeData, bus.Dummy_Read}), 64'h0);
        bus.req = 3'b011;
        tick();
        reset = 1'b0;
        wait_gnt("rst");
        chk("rst_next_gnt0", 64'(bus.gnt), 64'b001);
        wait_done("rst");
        bus.req = '0;
        tick();

        // Engine never leaves Wait
        eng_stall = 1'b1;
        bus.req = 3'b001;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.NewCommand && cnt < 20);
`ifdef KSZ_ARB_TIMEOUT_EN
        cnt = 0;
        while (bus.done == '0 && cnt < 60) begin
            tick();
            cnt++;
        end
        chk("tmo_cycles", 64'(cnt), 64'd21);
        chk("tmo_done", 64'(bus.done), 64'b001);
        chk("tmo_err", 64'(bus.err), 64'b001);
        chk("tmo_rdata", 64'(bus.rdata), 64'h0);
        bus.req = '0;
        tick();
        chk("tmo_release", 64'(bus.gnt), 64'h0);
`else
        bad = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.done !== 3'b000 || bus.err !== 3'b000) bad = 1'b1;
        end
        chk("notmo_no_done", 64'(bad), 64'h0);
        chk("notmo_still_issue", 64'({bus.gnt, bus.NewCommand}), 64'({3'b001, 1'b1}));
        bus.req = '0;
`endif
        eng_stall = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
